// File: rtl/soc_fpga_pattern_reader.sv
// soc_fpga_pattern_reader: streams a contiguous RAM range onto a valid/ready port via a 2-entry skid FIFO (optional looping under SOC_PAT_LOOP_EN)
module soc_fpga_pattern_reader #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 10
) (
  input  logic                 PortAClk,
  input  logic                 PortAReset,
  input  logic                 Start,
  input  logic [ADDRWIDTH-1:0] StartAddr,
  input  logic [ADDRWIDTH:0]   WordCount,
`ifdef SOC_PAT_LOOP_EN
  input  logic                 Loop,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut,
  output logic [DATAWIDTH-1:0] OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 OutLast
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, stateNext;
  logic [ADDRWIDTH-1:0] addr, addrNext;
  logic [ADDRWIDTH:0] remaining, remainingNext;
  logic [DATAWIDTH-1:0] fifoData [2];
  logic [1:0] fifoLast, occupancy;
  logic rdPtr, wrPtr, inFlight, inFlightLast, zeroDone;
  logic accept, pop, issue, finalIssue, reload, drained;
  assign accept     = state == IDLE && Start && WordCount != '0;
  assign pop        = OutValid && OutReady;
  assign issue      = state == RUN && remaining != '0 && (occupancy + {1'b0, inFlight}) <= ({1'b0, pop} + 2'd1);
  assign finalIssue = issue && remaining == {{ADDRWIDTH{1'b0}}, 1'b1};
  assign drained    = state == DRAIN && occupancy == 2'd0 && !inFlight;
`ifdef SOC_PAT_LOOP_EN
  logic [ADDRWIDTH-1:0] addrBase;
  logic [ADDRWIDTH:0] countBase;
  // Remember the range so a looping pass can restart it without a new Start
  always_ff @(posedge PortAClk) begin
    if (PortAReset) begin
      addrBase  <= '0;
      countBase <= '0;
    end else if (accept) begin
      addrBase  <= StartAddr;
      countBase <= WordCount;
    end
  end
  assign reload        = finalIssue && Loop;
  assign addrNext      = reload ? addrBase : addr + 1'b1;
  assign remainingNext = reload ? countBase : remaining - 1'b1;
`else
  assign reload        = 1'b0;
  assign addrNext      = addr + 1'b1;
  assign remainingNext = remaining - 1'b1;
`endif
  // Next-state: RUN until the final read of a non-looping pass, then DRAIN until the pipe is empty
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = accept ? RUN : IDLE;
      RUN:     stateNext = (finalIssue && !reload) ? DRAIN : RUN;
      DRAIN:   stateNext = drained ? IDLE : DRAIN;
      default: stateNext = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge PortAClk) begin
    if (PortAReset) state <= IDLE;
    else            state <= stateNext;
  end
  // Read issue, in-flight tracking for the one-cycle RAM latency, and the skid FIFO
  always_ff @(posedge PortAClk) begin
    if (PortAReset) begin
      addr         <= '0;
      remaining    <= '0;
      inFlight     <= 1'b0;
      inFlightLast <= 1'b0;
      zeroDone     <= 1'b0;
      fifoData     <= '{default: '0};
      fifoLast     <= '0;
      rdPtr        <= 1'b0;
      wrPtr        <= 1'b0;
      occupancy    <= 2'd0;
    end else begin
      zeroDone     <= state == IDLE && Start && WordCount == '0;
      inFlight     <= issue;
      inFlightLast <= finalIssue;
      if (accept) begin
        addr      <= StartAddr;
        remaining <= WordCount;
      end else if (issue) begin
        addr      <= addrNext;
        remaining <= remainingNext;
      end
      if (inFlight) begin
        fifoData[wrPtr] <= RamDataOut;
        fifoLast[wrPtr] <= inFlightLast;
        wrPtr           <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      occupancy <= occupancy + {1'b0, inFlight} - {1'b0, pop};
    end
  end
  assign RamAddr        = addr;
  assign RamWriteEnable = 1'b0;
  assign OutValid       = occupancy != 2'd0;
  assign OutData        = fifoData[rdPtr];
  assign OutLast        = OutValid && fifoLast[rdPtr];
  assign Busy           = state != IDLE;
  assign Done           = zeroDone || drained;
endmodule

// File: tb/tb_soc_fpga_pattern_reader.sv
// tb_soc_fpga_pattern_reader: directed checks of the pattern reader against a registered-read RAM model
module tb_soc_fpga_pattern_reader;
  localparam int DW = 32;
  localparam int AW = 4;
  logic PortAClk = 1'b0, PortAReset = 1'b1, Start = 1'b0, OutReady = 1'b1;
  logic [AW-1:0] StartAddr = '0;
  logic [AW:0] WordCount = '0;
`ifdef SOC_PAT_LOOP_EN
  logic Loop = 1'b0;
`endif
  logic Busy, Done, RamWriteEnable, OutValid, OutLast;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDataOut, OutData;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] beatData [$];
  logic beatLast [$];
  int beatCyc [$];
  int doneCyc [$];
  int edgeCnt = 0, e0 = 0, checks = 0, failures = 0;
  logic [DW-1:0] exp4 [4];

  soc_fpga_pattern_reader #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .PortAClk(PortAClk), .PortAReset(PortAReset), .Start(Start), .StartAddr(StartAddr),
    .WordCount(WordCount),
`ifdef SOC_PAT_LOOP_EN
    .Loop(Loop),
`endif
    .Busy(Busy), .Done(Done), .RamAddr(RamAddr), .RamWriteEnable(RamWriteEnable),
    .RamDataOut(RamDataOut), .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .OutLast(OutLast)
  );

  always #5 PortAClk = ~PortAClk;
  // RAM model: data of the address presented in the previous cycle
  always @(posedge PortAClk) RamDataOut <= mem[RamAddr];
  always @(posedge PortAClk) edgeCnt <= edgeCnt + 1;
  // Beat and Done monitor; cycle 1 is the cycle after the Start edge
  always @(negedge PortAClk) begin
    if (!PortAReset && OutValid && OutReady) begin
      beatData.push_back(OutData);
      beatLast.push_back(OutLast);
      beatCyc.push_back(edgeCnt - e0 + 1);
    end
    if (!PortAReset && Done) doneCyc.push_back(edgeCnt - e0 + 1);
  end

  task automatic tick();
    @(posedge PortAClk);
    #1;
  endtask

  task automatic clearMon();
    beatData.delete();
    beatLast.delete();
    beatCyc.delete();
    doneCyc.delete();
  endtask

  task automatic startXfer(input int a, input int n);
    Start = 1'b1;
    StartAddr = AW'(a);
    WordCount = (AW + 1)'(n);
    tick();
    e0 = edgeCnt;
    Start = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc);
    for (int i = 0; i < maxCyc; i++) begin
      tick();
      if (doneCyc.size() != 0) break;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    PortAReset = 1'b1;
    tick();
    tick();
    checks++;
    if ({Busy, Done, OutValid, OutLast, RamWriteEnable} !== 5'b0 || RamAddr !== '0 || OutData !== '0) begin
      failures++;
      $display("FAIL reset: Busy/Done/Valid/Last/We=%b%b%b%b%b RamAddr=%0h OutData=%0h required all zero",
               Busy, Done, OutValid, OutLast, RamWriteEnable, RamAddr, OutData);
    end
    PortAReset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    clearMon();
    OutReady = 1'b1;
    startXfer(4, 4);
    checks++;
    if (Busy !== 1'b1 || RamAddr !== 4'd4) begin
      failures++;
      $display("FAIL stream_issue: Busy=%b RamAddr=%0d required Busy=1 RamAddr=4", Busy, RamAddr);
    end
    waitDone(20);
    checks++;
    if (beatData.size() !== 4) begin
      failures++;
      $display("FAIL stream_count: got %0d beats required 4", beatData.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beatData[i] !== exp4[i] || beatCyc[i] !== 3 + i || beatLast[i] !== (i == 3)) begin
          failures++;
          $display("FAIL stream_beat%0d: data=%0h cyc=%0d last=%b required data=%0h cyc=%0d last=%b",
                   i, beatData[i], beatCyc[i], beatLast[i], exp4[i], 3 + i, i == 3);
        end
      end
    end
    checks++;
    if (doneCyc.size() !== 1 || doneCyc[0] !== 7) begin
      failures++;
      $display("FAIL stream_done: pulses=%0d first_cycle=%0d required 1 pulse in cycle 7",
               doneCyc.size(), doneCyc.size() ? doneCyc[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    clearMon();
    OutReady = 1'b1;
    startXfer(4, 4);
    tick();
    tick();
    OutReady = 1'b0;
    for (int k = 3; k <= 9; k++) begin
      checks++;
      if (OutValid !== 1'b1 || OutData !== 32'h11) begin
        failures++;
        $display("FAIL bp_hold_c%0d: valid=%b data=%0h required valid=1 data=11", k, OutValid, OutData);
      end
      if (k == 9) begin
        checks++;
        if (RamAddr !== 4'd6) begin
          failures++;
          $display("FAIL bp_stall: RamAddr=%0d required 6", RamAddr);
        end
      end
      tick();
    end
    OutReady = 1'b1;
    waitDone(20);
    checks++;
    if (beatData.size() !== 4) begin
      failures++;
      $display("FAIL bp_count: got %0d beats required 4", beatData.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beatData[i] !== exp4[i] || beatCyc[i] !== 10 + i || beatLast[i] !== (i == 3)) begin
          failures++;
          $display("FAIL bp_beat%0d: data=%0h cyc=%0d last=%b required data=%0h cyc=%0d last=%b",
                   i, beatData[i], beatCyc[i], beatLast[i], exp4[i], 10 + i, i == 3);
        end
      end
    end
    checks++;
    if (doneCyc.size() !== 1 || doneCyc[0] !== 14) begin
      failures++;
      $display("FAIL bp_done: pulses=%0d first_cycle=%0d required 1 pulse in cycle 14",
               doneCyc.size(), doneCyc.size() ? doneCyc[0] : -1);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] expAddr [4];
    logic [DW-1:0] expData [4];
    expAddr = '{4'd14, 4'd15, 4'd0, 4'd1};
    expData = '{32'hE0, 32'hF0, 32'hA0, 32'hA1};
    mem[14] = 32'hE0;
    mem[15] = 32'hF0;
    mem[0] = 32'hA0;
    mem[1] = 32'hA1;
    clearMon();
    startXfer(14, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RamAddr !== expAddr[i]) begin
        failures++;
        $display("FAIL wrap_addr%0d: RamAddr=%0d required %0d", i, RamAddr, expAddr[i]);
      end
      if (i != 3) tick();
    end
    waitDone(20);
    checks++;
    if (beatData.size() !== 4 || beatData[0] !== expData[0] || beatData[1] !== expData[1] ||
        beatData[2] !== expData[2] || beatData[3] !== expData[3]) begin
      failures++;
      $display("FAIL wrap_data: beats=%0d required E0,F0,A0,A1 in order", beatData.size());
    end
  endtask

  task automatic test_zero_count();
    clearMon();
    startXfer(3, 0);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: Done=%b Busy=%b required Done=1 Busy=0", Done, Busy);
    end
    tick();
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse: Done=%b required 0", Done);
    end
    repeat (4) tick();
    checks++;
    if (beatData.size() !== 0 || doneCyc.size() !== 1) begin
      failures++;
      $display("FAIL zero_beats: beats=%0d dones=%0d required 0 beats 1 done", beatData.size(), doneCyc.size());
    end
  endtask

  task automatic test_start_while_busy();
    clearMon();
    startXfer(4, 4);
    tick();
    Start = 1'b1;
    StartAddr = 4'd0;
    WordCount = 5'd2;
    tick();
    Start = 1'b0;
    waitDone(20);
    checks++;
    if (beatData.size() !== 4 || beatData[0] !== exp4[0] || beatData[3] !== exp4[3] ||
        doneCyc.size() !== 1 || doneCyc[0] !== 7) begin
      failures++;
      $display("FAIL busy_start: beats=%0d dones=%0d required 4 beats 11..44 and one Done in cycle 7",
               beatData.size(), doneCyc.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) mem[i] = 32'hB0 + i;
    clearMon();
    startXfer(0, 8);
    repeat (4) tick();
    PortAReset = 1'b1;
    tick();
    checks++;
    if ({Busy, Done, OutValid, OutLast, RamWriteEnable} !== 5'b0 || RamAddr !== '0 || OutData !== '0) begin
      failures++;
      $display("FAIL reset_mid: Busy/Done/Valid/Last/We=%b%b%b%b%b RamAddr=%0h OutData=%0h required all zero",
               Busy, Done, OutValid, OutLast, RamWriteEnable, RamAddr, OutData);
    end
    PortAReset = 1'b0;
    tick();
    clearMon();
    startXfer(4, 4);
    waitDone(20);
    checks++;
    if (beatData.size() !== 4 || beatData[0] !== exp4[0] || beatData[1] !== exp4[1] ||
        beatData[2] !== exp4[2] || beatData[3] !== exp4[3] || beatCyc[0] !== 3) begin
      failures++;
      $display("FAIL reset_restart: beats=%0d required 11,22,33,44 from cycle 3", beatData.size());
    end
  endtask

`ifdef SOC_PAT_LOOP_EN
  task automatic test_loop();
    mem[4] = 32'hAA;
    mem[5] = 32'hBB;
    clearMon();
    Loop = 1'b1;
    startXfer(4, 2);
    repeat (8) tick();
    Loop = 1'b0;
    waitDone(30);
    checks++;
    if (beatData.size() < 6 || beatData.size() % 2 != 0) begin
      failures++;
      $display("FAIL loop_count: beats=%0d required an even count of at least 6", beatData.size());
    end
    for (int i = 0; i < beatData.size(); i++) begin
      checks++;
      if (beatData[i] !== ((i % 2) ? 32'hBB : 32'hAA) || beatLast[i] !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL loop_beat%0d: data=%0h last=%b required data=%0h last=%b",
                 i, beatData[i], beatLast[i], (i % 2) ? 32'hBB : 32'hAA, i % 2 == 1);
      end
    end
    checks++;
    if (doneCyc.size() !== 1 || beatCyc.size() == 0 || doneCyc[0] !== beatCyc[beatCyc.size() - 1] + 1) begin
      failures++;
      $display("FAIL loop_done: dones=%0d required one Done right after the final beat", doneCyc.size());
    end
    mem[4] = 32'h11;
    mem[5] = 32'h22;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) mem[4 + i] = exp4[i];
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid();
`ifdef SOC_PAT_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
